// File: rtl/fast_control_pkg.sv
// Shared fast-control definitions: frame header/trailer, command code type,
// code legality check and frame construction. Also used by the fanout's
// cleanup and debug logic.
package fast_control_pkg;

    localparam logic [2:0] FC_HEADER  = 3'b110;
    localparam logic       FC_TRAILER = 1'b1;

    typedef logic [3:0] fc_code_t;

    // Codes that would place a 110 pattern inside the frame body and confuse
    // the receiver's header lock.
    function automatic logic fc_code_legal(input fc_code_t code);
        logic legal;
        case (code)
            4'h6, 4'hC, 4'hD, 4'hE: legal = 1'b0;
            default:                legal = 1'b1;
        endcase
        return legal;
    endfunction

    // Frame layout, MSB first: 1,1,0,p3,p2,p1,p0,1
    function automatic logic [7:0] fc_make_frame(input fc_code_t code);
        return {FC_HEADER, code, FC_TRAILER};
    endfunction

endpackage

// File: rtl/fc_cmd_fifo.sv
// Command FIFO for the fast-command encoder. Synchronous push/pop with
// full/empty/level, asynchronous active-high reset. DEPTH must be a power of
// two so the pointers wrap naturally.
module fc_cmd_fifo
    import fast_control_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fc_code_t                 data_i,
    input  logic                     pop_i,
    output fc_code_t                 data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    fc_code_t          mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Requests that cannot be honoured are dropped here as a safety net.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset flushes the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once level is 0.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fast_command_encoder.sv
// Fast-command encoder: accepts 4-bit codes over valid/ready, queues them,
// frames each as 110pppp1 and shifts the frame out MSB-first, one bit per
// int_fast_clock cycle. Idle frames fill the gaps.
// Optional periodic BCR insertion is built when FC_ENCODER_ORBIT_BCR_EN is
// defined; otherwise the orbit counter is absent and BCR_CODE/ORBIT_FRAMES
// are ignored.
module fast_command_encoder
    import fast_control_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ORBIT_FRAMES = 3564,
    parameter fc_code_t    BCR_CODE     = 4'h2,
    parameter fc_code_t    IDLE_CODE    = 4'h0
) (
    input  logic                          int_fast_clock,
    input  logic                          arst,
    input  logic                          enable,
    input  logic                          cmd_valid,
    input  fc_code_t                      cmd_code,
    output logic                          cmd_ready,
    output logic                          int_fast_command,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    illegal_count
);

    logic [2:0]  bit_ctr_q;
    logic [7:0]  shift_q;
    logic        frame_start_q;
    logic [7:0]  illegal_q, illegal_d;
    logic        load;
    logic        handshake;
    logic        code_legal;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    fc_code_t    fifo_head;
    logic        take_head;
    logic [7:0]  next_frame;

    // Every eighth edge (bit_ctr==7) loads a fresh frame; reset puts the
    // counter at 7 so the first edge after release is a load edge.
    assign load       = (bit_ctr_q == 3'd7);
    assign code_legal = fc_code_legal(cmd_code);
    assign handshake  = cmd_valid && cmd_ready;
    assign fifo_push  = handshake && code_legal;
    assign fifo_pop   = load && take_head;

    assign cmd_ready        = !fifo_full;
    assign int_fast_command = shift_q[7];
    assign frame_start      = frame_start_q;
    assign illegal_count    = illegal_q;

    fc_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (int_fast_clock),
        .rst_i   (arst),
        .push_i  (fifo_push),
        .data_i  (cmd_code),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

`ifdef FC_ENCODER_ORBIT_BCR_EN
    localparam int unsigned ORB_W = 12;

    logic [ORB_W-1:0] orbit_ctr_q;
    logic             bcr_due;

    assign bcr_due = enable && (orbit_ctr_q == '0);

    // Frame counter within the orbit; advances on every load edge even when
    // disabled so the BCR phase stays locked to the frame grid.
    always_ff @(posedge int_fast_clock or posedge arst) begin
        if (arst) begin
            orbit_ctr_q <= '0;
        end else if (load) begin
            if (orbit_ctr_q == ORB_W'(ORBIT_FRAMES - 1)) begin
                orbit_ctr_q <= '0;
            end else begin
                orbit_ctr_q <= orbit_ctr_q + ORB_W'(1);
            end
        end
    end

    // Next-frame priority: BCR, then FIFO head, then idle. A head displaced
    // by BCR stays in the FIFO and goes out in the following frame.
    always_comb begin
        next_frame = fc_make_frame(IDLE_CODE);
        take_head  = 1'b0;
        if (bcr_due) begin
            next_frame = fc_make_frame(BCR_CODE);
        end else if (enable && !fifo_empty) begin
            next_frame = fc_make_frame(fifo_head);
            take_head  = 1'b1;
        end
    end
`else
    logic unused_bcr_cfg;
    assign unused_bcr_cfg = ^{BCR_CODE, 12'(ORBIT_FRAMES)};

    // Next-frame priority: FIFO head, then idle.
    always_comb begin
        next_frame = fc_make_frame(IDLE_CODE);
        take_head  = 1'b0;
        if (enable && !fifo_empty) begin
            next_frame = fc_make_frame(fifo_head);
            take_head  = 1'b1;
        end
    end
`endif

    // Bit counter, serializer and frame marker; reset abandons any partial
    // frame.
    always_ff @(posedge int_fast_clock or posedge arst) begin
        if (arst) begin
            bit_ctr_q     <= 3'd7;
            shift_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            bit_ctr_q     <= bit_ctr_q + 3'd1;
            frame_start_q <= load;
            if (load) begin
                shift_q <= next_frame;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    // Saturating count of consumed-but-rejected codes.
    always_comb begin
        illegal_d = illegal_q;
        if (handshake && !code_legal && (illegal_q != 8'hFF)) begin
            illegal_d = illegal_q + 8'd1;
        end
    end

    // Illegal-code counter register.
    always_ff @(posedge int_fast_clock or posedge arst) begin
        if (arst) begin
            illegal_q <= '0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: doc/fast_command_encoder.md
# fast_command_encoder

Generates the serial internal fast-command stream (`int_fast_command`) that the fast-control fanout resynchronises, cleans and drives off-chip. It accepts 4-bit command codes from the control logic over a valid/ready handshake and buffers them in a small FIFO. Each code is framed into the 8-bit `110 pppp 1` format that the fanout's header-lock logic expects, and the frame is shifted out MSB-first, one bit per `int_fast_clock` cycle. When no command is pending the block emits idle frames, and it can insert a periodic bunch-count-reset (BCR).

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, 2–16.
- `ORBIT_FRAMES`, 3564: frames per orbit (BCR period); 2–4095.
- `BCR_CODE`, 4'h2: payload sent for the periodic BCR; must be a legal code.
- `IDLE_CODE`, 4'h0: payload of the idle frame.

Ports:
- `int_fast_clock`  in  1  fast clock; sole clock. All logic is on the rising edge.
- `arst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  when low, only idle frames are sent; the FIFO holds its contents.
- `cmd_valid`  in  1  command offered.
- `cmd_code`  in  4  command payload.
- `cmd_ready`  out  1  FIFO not full.
- `int_fast_command`  out  1  serial frame bit, driven directly from a flop.
- `frame_start`  out  1  high during the first (MSB) bit of each frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `illegal_count`  out  8  saturating count of rejected illegal codes.

## Operation
- Frame format, MSB first: `1,1,0,p3,p2,p1,p0,1`.
- Illegal payloads are codes that would recreate the `110` header inside the frame: 4'h6, 4'hC, 4'hD, 4'hE. On handshake (`cmd_valid && cmd_ready`), an illegal code is consumed but not written to the FIFO, and `illegal_count` increments, saturating at 255. Legal codes are written to the FIFO.
- `bit_ctr` (3 bits) is free-running. A load edge is any edge where `bit_ctr==7`. On a load edge the shift register is loaded with the next frame; on all other edges it shifts left with 0 fill.
- Next-frame priority on a load edge:
  1. BCR, when the macro is enabled, `enable=1` and `orbit_ctr==0`.
  2. FIFO head, when `enable=1` and the FIFO is non-empty; the head is popped.
  3. Idle frame.
- A FIFO entry displaced by a BCR is sent in the next frame, with no loss or reorder.
- `orbit_ctr` increments on every load edge, independent of `enable`, and wraps from `ORBIT_FRAMES-1` to 0.
- Simultaneous push and pop: `fifo_level` is unchanged and the data order is preserved. A push while full cannot occur because `cmd_ready=0`.
- Reset mid-frame: the partial frame is abandoned and the FIFO is flushed. `illegal_count` and `orbit_ctr` are cleared.

## Timing
- Reset values:
  - `int_fast_command=0`, `frame_start=0`, `cmd_ready=1`, `fifo_level=0`, `illegal_count=0`
  - `bit_ctr=7`, shift register = 0, `orbit_ctr=0`
- First clock edge after `arst` deasserts is a load edge, so the first frame starts one cycle after release.
- `frame_start` is registered and aligned with bit 7 of each frame: high for 1 cycle in every 8.
- Command latency: a push at edge E is eligible from the first load edge strictly after E. From an empty FIFO, the MSB appears 1 to 8 cycles after the push. The payload nibble follows 3 cycles after the MSB.
- `cmd_ready` updates the cycle after the push or pop that changes fullness.
- Sustained throughput is one command per 8 cycles.

## Configuration
- `FC_ENCODER_ORBIT_BCR_EN` defined: `orbit_ctr` and BCR insertion are present as described.
- Not defined: `orbit_ctr` is removed and priority is FIFO head, then idle. `BCR_CODE` and `ORBIT_FRAMES` are ignored.

## Structure
- Shared package `fast_control_pkg`:
  - `FC_HEADER` = 3'b110
  - `FC_TRAILER` = 1'b1
  - `fc_code_t` (logic [3:0])
  - function `fc_code_legal()`
  - function `fc_make_frame()`, returning 8 bits

  This package is also used by the fanout's cleanup and debug logic.
- One sub-module, `fc_cmd_fifo`: a synchronous FIFO with push/pop/full/empty/level, async active-high reset, and storage width of `fc_code_t`.

## Test plan
- Reset release with no commands, `enable=1`, macro off → `int_fast_command` repeats 11000001 every 8 cycles; `frame_start` high on each leading 1.
- Push 4'h3 into an empty FIFO → next frame is 11000111; `fifo_level` returns 0 after the load edge.
- Push 4'h6 → `illegal_count`=1, no frame change, FIFO stays empty. Push 256 illegal codes → count holds at 255.
- Fill 4 entries (4'h1, 4'h2, 4'h3, 4'h4) back-to-back → `cmd_ready`=0 after the 4th push; frames carry 1, 2, 3, 4 in order on consecutive frames.
- Macro on, `ORBIT_FRAMES`=4, queued 4'h5 coinciding with `orbit_ctr`=0 → BCR frame 11000101 first, then 11001011.
- `enable=0` with 2 queued entries, then `arst` pulsed mid-frame → only idle frames while disabled; after reset `fifo_level`=0 and output restarts 1 cycle after release.
